dest_to_user: RTL and testbench
===============================

DEST_TO_USER -- requirements
Module: dest_to_user

Interface
REQ-001 SHALL have no parameters; data 8 bits, tdest/tuser 2 bits, fixed.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset; one clock, synchronous and active-high.
REQ-004 s_axis_tdata  input  8  input stream data.
REQ-005 s_axis_tvalid  input  1  input beat valid.
REQ-006 s_axis_tready  output  1  input beat accept.
REQ-007 s_axis_tlast  input  1  last beat of frame.
REQ-008 s_axis_tdest  input  2  destination/queue class of beat.
REQ-009 m_axis_tdata  output  8  output stream data.
REQ-010 m_axis_tvalid  output  1  output beat valid.
REQ-011 m_axis_tready  input  1  output beat accept.
REQ-012 m_axis_tlast  output  1  last beat of frame.
REQ-013 m_axis_tuser  output  2  class carried as sideband, derived from tdest.
REQ-014 frame_cnt  output  16  completed output frames (tlast handshakes on m side), wraps 0xFFFF->0x0000.
REQ-015 dest_mismatch  output  1  sticky: tdest changed mid-frame on input.

Function
REQ-016 SHALL be a 2-entry register slice (main + skid register); all m_axis_* outputs driven from registers.
REQ-017 Latency SHALL be 1 cycle: beat accepted at edge N appears on m_axis at cycle N+1 if main register empty or draining.
REQ-018 s_axis_tready SHALL be registered and equal NOT(skid register occupied); full throughput (1 beat/cycle) SHALL be sustained while m_axis_tready=1.
REQ-019 When m_axis_tready=0 and main register full, one further accepted beat SHALL be stored in skid; s_axis_tready SHALL drop the following cycle.
REQ-020 When main register drains and skid occupied, skid SHALL move to main on the same edge; s_axis_tready SHALL return to 1 the next cycle.
REQ-021 Once m_axis_tvalid=1, m_axis_tdata/tlast/tuser SHALL stay stable until m_axis_tready=1.
REQ-022 Beat order SHALL be preserved; no beat dropped or duplicated.
REQ-023 Input frame state: IDLE (next beat is first of frame) and IN_FRAME; IDLE->IN_FRAME on accepted beat with tlast=0; IN_FRAME->IDLE on accepted beat with tlast=1; single-beat frame stays IDLE.
REQ-024 First-beat tdest SHALL be latched into frame_dest register at the IDLE accept.
REQ-025 dest_mismatch SHALL set when an accepted IN_FRAME beat has tdest != frame_dest; cleared only by rst.
REQ-026 frame_cnt SHALL increment by 1 on each m_axis_tvalid&m_axis_tready&m_axis_tlast edge.
REQ-027 Simultaneous input accept and output drain SHALL both take effect on the same edge.

Reset
REQ-028 While rst=1: main/skid valid=0, m_axis_tvalid=0, s_axis_tready=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, frame state IDLE, frame_dest=0, frame_cnt=0, dest_mismatch=0.
REQ-029 s_axis_tready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 Reset mid-frame SHALL discard buffered beats; next accepted beat is treated as a first beat.

Configuration
REQ-031 Macro DEST_TO_USER_FRAME_LOCK_EN: defined -> m_axis_tuser for every beat of a frame SHALL equal the first-beat tdest (frame_dest, or s_axis_tdest for the first beat itself).
REQ-032 Undefined -> m_axis_tuser SHALL equal that beat's own s_axis_tdest; frame tracking and dest_mismatch SHALL remain active.

Verification
REQ-033 Frame of 4 beats, tdata 0x10..0x13, tdest=2, m_axis_tready=1 -> output 0x10..0x13 one cycle delayed, tuser=2 all beats, tlast on 0x13, frame_cnt=1.
REQ-034 Same frame, m_axis_tready=0 for 3 cycles -> exactly 2 beats buffered, s_axis_tready=0 from the cycle after skid fills, outputs stable, no loss after release.
REQ-035 Frame tdest 1,1,3,1 -> LOCK_EN: tuser 1,1,1,1, dest_mismatch=1; no LOCK_EN: tuser 1,1,3,1, dest_mismatch=1.
REQ-036 65536 single-beat frames -> frame_cnt wraps to 0x0000.
REQ-037 rst asserted after beat 2 of 4-beat frame -> m_axis_tvalid=0 next cycle; new frame tdest=0 gets tuser=0 on all beats.
REQ-038 Random tvalid/tready (50%), 1000 frames -> output beat sequence identical to input, tuser per REQ-031/032.

Source files
------------

// File: rtl/dest_to_user.sv
`default_nettype none
// ============================================================================
// Module   : dest_to_user
// Purpose  : Two-entry AXI-Stream register slice (main + skid) that carries
//            the input tdest through as the output tuser sideband. It tracks
//            frames on the input side, flags a tdest change inside a frame,
//            and counts completed output frames.
// Ports    : clk, rst               - single clock, synchronous active-high reset
//            s_axis_tdata/tvalid/tready/tlast/tdest - 8-bit input stream
//            m_axis_tdata/tvalid/tready/tlast/tuser - 8-bit output stream
//            frame_cnt      - completed output frames, 16-bit wrapping
//            dest_mismatch  - sticky flag: tdest changed within an input frame
// Config   : DEST_TO_USER_FRAME_LOCK_EN - when defined, every beat of a frame
//            carries the first beat's tdest on tuser; otherwise each beat
//            carries its own tdest.
// Revision : 1.0 - initial release
// ============================================================================
module dest_to_user (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [1:0]  s_axis_tdest,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [1:0]  m_axis_tuser,
  output logic [15:0] frame_cnt,
  output logic        dest_mismatch
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

  frame_state_t frame_state;
  logic [1:0]   frame_dest;

  // Main register drives the m_axis outputs directly.
  logic       main_valid;
  logic [7:0] main_data;
  logic       main_last;
  logic [1:0] main_user;

  // Skid register catches the one beat accepted while main is stalled.
  logic       skid_valid;
  logic [7:0] skid_data;
  logic       skid_last;
  logic [1:0] skid_user;

  logic       accept;
  logic       main_free;
  logic [1:0] in_user;

  assign accept    = s_axis_tvalid & s_axis_tready;
  // Main can take a new beat when it is empty or is being drained this edge.
  assign main_free = ~main_valid | m_axis_tready;

`ifdef DEST_TO_USER_FRAME_LOCK_EN
  // First beat of a frame has not been latched yet, so use its own tdest.
  assign in_user = (frame_state == IDLE) ? s_axis_tdest : frame_dest;
`else
  assign in_user = s_axis_tdest;
`endif

  assign m_axis_tvalid = main_valid;
  assign m_axis_tdata  = main_data;
  assign m_axis_tlast  = main_last;
  assign m_axis_tuser  = main_user;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid    <= 1'b0;
      main_data     <= 8'd0;
      main_last     <= 1'b0;
      main_user     <= 2'd0;
      skid_valid    <= 1'b0;
      skid_data     <= 8'd0;
      skid_last     <= 1'b0;
      skid_user     <= 2'd0;
      s_axis_tready <= 1'b0;
    end else if (main_free) begin
      // s_axis_tready is low whenever skid is occupied, so accept and a
      // skid-to-main transfer never coincide.
      s_axis_tready <= 1'b1;
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_last  <= skid_last;
        main_user  <= skid_user;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_data  <= s_axis_tdata;
        main_last  <= s_axis_tlast;
        main_user  <= in_user;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid    <= 1'b1;
      skid_data     <= s_axis_tdata;
      skid_last     <= s_axis_tlast;
      skid_user     <= in_user;
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= ~skid_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 16'd0;
    end else if (main_valid && m_axis_tready && main_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_state   <= IDLE;
      frame_dest    <= 2'd0;
      dest_mismatch <= 1'b0;
    end else if (accept) begin
      case (frame_state)
        IDLE: begin
          frame_dest <= s_axis_tdest;
          if (!s_axis_tlast) begin
            frame_state <= IN_FRAME;
          end
        end
        IN_FRAME: begin
          if (s_axis_tdest != frame_dest) begin
            dest_mismatch <= 1'b1;
          end
          if (s_axis_tlast) begin
            frame_state <= IDLE;
          end
        end
        default: frame_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dest_to_user.sv
`default_nettype none
// ============================================================================
// Module   : tb_dest_to_user
// Purpose  : Self-checking bench for dest_to_user. A queue model of the
//            beats held inside the slice predicts the outputs every cycle;
//            directed sequences add literal expectations on top.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dest_to_user;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = 8'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [1:0]  s_axis_tdest = 2'd0;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [1:0]  m_axis_tuser;
  logic [15:0] frame_cnt;
  logic        dest_mismatch;

  dest_to_user dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdest  (s_axis_tdest),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .frame_cnt     (frame_cnt),
    .dest_mismatch (dest_mismatch)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] u;
  } beat_t;

  beat_t       q[$];        // beats accepted and not yet delivered
  beat_t       out_log[$];  // delivered beats, for directed checks
  beat_t       popped;
  beat_t       pushed;
  bit          log_en  = 1'b0;
  bit          held    = 1'b1; // last clock edge had reset asserted
  logic [15:0] m_cnt   = 16'd0;
  bit          m_mis   = 1'b0;
  bit          m_first = 1'b1;
  logic [1:0]  m_dest  = 2'd0;
  int          n_in    = 0;
  int          n_out   = 0;
  bit          acc_m;
  bit          done    = 1'b0;

  always @(negedge clk) begin
    if (held) begin
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_m_tlast", m_axis_tlast, 0);
      chk("rst_m_tuser", m_axis_tuser, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_dest_mismatch", dest_mismatch, 0);
    end else begin
      chk("m_tvalid", m_axis_tvalid, q.size() != 0);
      chk("s_tready", s_axis_tready, q.size() < 2);
      if (q.size() != 0) chk("m_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, q[0]);
      chk("frame_cnt", frame_cnt, m_cnt);
      chk("dest_mismatch", dest_mismatch, m_mis);
    end

    if (rst) begin
      q.delete();
      m_cnt = 16'd0; m_mis = 1'b0; m_first = 1'b1; m_dest = 2'd0;
      n_in = 0; n_out = 0;
      held = 1'b1;
    end else begin
      acc_m = !held && s_axis_tvalid && (q.size() < 2);
      if (!held && q.size() != 0 && m_axis_tready) begin
        popped = q.pop_front();
        if (popped.l) m_cnt = m_cnt + 16'd1;
        if (log_en) out_log.push_back(popped);
        n_out++;
      end
      if (acc_m) begin
        if (m_first) m_dest = s_axis_tdest;
        else if (s_axis_tdest != m_dest) m_mis = 1'b1;
        pushed.d = s_axis_tdata;
        pushed.l = s_axis_tlast;
`ifdef DEST_TO_USER_FRAME_LOCK_EN
        pushed.u = m_dest;
`else
        pushed.u = s_axis_tdest;
`endif
        m_first = s_axis_tlast;
        q.push_back(pushed);
        n_in++;
      end
      held = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] t);
    bit acc = 1'b0;
    int n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tdest  = t;
    s_axis_tvalid = 1'b1;
    while (!acc && n < 200) begin
      acc = s_axis_tready;
      tick();
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_log(input string name, input int idx, input logic [7:0] d,
                         input logic l, input logic [1:0] u);
    if (idx < out_log.size()) begin
      chk({name, "_data"}, out_log[idx].d, d);
      chk({name, "_last"}, out_log[idx].l, l);
      chk({name, "_user"}, out_log[idx].u, u);
    end else begin
      chk({name, "_missing"}, idx, out_log.size());
    end
  endtask

  logic [1:0] exp_u[4];
  int         len;
  logic [1:0] base_dest;
  logic [1:0] bd;

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("ready_after_rst", s_axis_tready, 1);

    // 4-beat frame, sink always ready
    m_axis_tready = 1'b1;
    log_en = 1'b1;
    out_log.delete();
    send(8'h10, 1'b0, 2'd2);
    chk("latency_valid", m_axis_tvalid, 1);
    chk("latency_data", m_axis_tdata, 8'h10);
    send(8'h11, 1'b0, 2'd2);
    send(8'h12, 1'b0, 2'd2);
    send(8'h13, 1'b1, 2'd2);
    repeat (2) tick();
    chk("f1_frame_cnt", frame_cnt, 1);
    chk("f1_count", out_log.size(), 4);
    for (int i = 0; i < 4; i++) chk_log("f1", i, 8'h10 + 8'(i), i == 3, 2'd2);

    // Stall: two beats buffered, ready drops, outputs hold
    do_reset();
    out_log.delete();
    m_axis_tready = 1'b0;
    send(8'h10, 1'b0, 2'd2);
    send(8'h11, 1'b0, 2'd2);
    chk("stall_ready", s_axis_tready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_data", m_axis_tdata, 8'h10);
      chk("stall_valid", m_axis_tvalid, 1);
      tick();
    end
    m_axis_tready = 1'b1;
    send(8'h12, 1'b0, 2'd2);
    send(8'h13, 1'b1, 2'd2);
    repeat (3) tick();
    chk("f2_frame_cnt", frame_cnt, 1);
    for (int i = 0; i < 4; i++) chk_log("f2", i, 8'h10 + 8'(i), i == 3, 2'd2);

    // tdest change mid-frame
    do_reset();
    out_log.delete();
`ifdef DEST_TO_USER_FRAME_LOCK_EN
    exp_u = '{2'd1, 2'd1, 2'd1, 2'd1};
`else
    exp_u = '{2'd1, 2'd1, 2'd3, 2'd1};
`endif
    send(8'h20, 1'b0, 2'd1);
    send(8'h21, 1'b0, 2'd1);
    send(8'h22, 1'b0, 2'd3);
    send(8'h23, 1'b1, 2'd1);
    repeat (2) tick();
    chk("f3_mismatch", dest_mismatch, 1);
    for (int i = 0; i < 4; i++) chk_log("f3", i, 8'h20 + 8'(i), i == 3, exp_u[i]);

    // Reset mid-frame discards buffered beats
    do_reset();
    m_axis_tready = 1'b0;
    send(8'h30, 1'b0, 2'd1);
    send(8'h31, 1'b0, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", m_axis_tvalid, 0);
    tick();
    chk("midrst_ready", s_axis_tready, 1);
    m_axis_tready = 1'b1;
    out_log.delete();
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), i == 3, 2'd0);
    repeat (2) tick();
    chk("f4_frame_cnt", frame_cnt, 1);
    chk("f4_mismatch", dest_mismatch, 0);
    chk("f4_count", out_log.size(), 4);
    for (int i = 0; i < 4; i++) chk_log("f4", i, 8'h40 + 8'(i), i == 3, 2'd0);

    // frame_cnt wrap with single-beat frames
    do_reset();
    log_en = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 65535; i++) send(8'(i), 1'b1, 2'(i));
    repeat (2) tick();
    chk("wrap_ffff", frame_cnt, 16'hFFFF);
    send(8'hAA, 1'b1, 2'd0);
    repeat (2) tick();
    chk("wrap_zero", frame_cnt, 16'h0000);

    // Random valid/ready traffic
    do_reset();
    done = 1'b0;
    fork
      begin
        while (!done) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      begin
        for (int f = 0; f < 1000; f++) begin
          len = $urandom_range(1, 3);
          base_dest = 2'($urandom_range(0, 3));
          for (int b = 0; b < len; b++) begin
            while ($urandom_range(0, 1) == 1) tick();
            bd = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : base_dest;
            send(8'($urandom_range(0, 255)), b == len - 1, bd);
          end
        end
        done = 1'b1;
      end
    join
    m_axis_tready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    tick();
    chk("rand_drained", q.size(), 0);
    chk("rand_beats", n_out, n_in);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
